tribus_arbiter: RTL and testbench

- Round-robin arbiter for a shared `inout tri logic` bus with N_REQ potential drivers.
- Grants bus ownership to exactly one requester at a time.
- Generates per-requester tri-state drive enables and enforces a programmable idle turnaround between owners, so the bus is never multi-driven.
- Sits beside the shared net, one level above the child modules that own the tri-state buffers.

---
 rtl/tribus_arbiter.sv | 138 +++++++++++++
 tb/tb_tribus_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tribus_arbiter.sv
// Round-robin owner arbiter for a shared tri-state bus, with an idle turnaround between owners.
// Optional protocol checker (o_err and assertions) under TRIBUS_ARBITER_PROTOCOL_CHECK_EN.
module tribus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ-1:0]         i_done,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [N_REQ-1:0]         o_drive_en,
  output logic                     o_busy,
  output logic [$clog2(N_REQ)-1:0] o_owner,
  output logic                     o_preempt
`ifdef TRIBUS_ARBITER_PROTOCOL_CHECK_EN
  ,
  output logic                     o_err
`endif
);
  localparam int IW = $clog2(N_REQ);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  // turn counter holds TURNAROUND-1 at most
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] last, last_nxt, win;
  logic          win_vld;
  logic [HW-1:0] hold, hold_nxt;
  logic [TW-1:0] turn, turn_nxt;
  logic          preempt_nxt, arb;
  logic [N_REQ-1:0] own_mask;
  logic          own_req, own_done, others, at_max, force_rel;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    int j;
    j = int'(base) + k;
    if (j >= N_REQ) j = j - N_REQ;
    return IW'(j);
  endfunction

  // highest k first so the nearest requester after `last` wins
  always_comb begin
    win_vld = 1'b0;
    win     = last;
    for (int k = N_REQ; k >= 1; k--) begin
      if (i_req[rr_idx(last, k)]) begin
        win_vld = 1'b1;
        win     = rr_idx(last, k);
      end
    end
  end

  assign own_mask  = N_REQ'(1) << last;
  assign own_req   = i_req[last];
  assign own_done  = i_done[last];
  assign others    = |(i_req & ~own_mask);
  assign at_max    = (MAX_HOLD > 0) && (hold == HW'(MAX_HOLD));
  assign force_rel = at_max && others;

  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    hold_nxt    = hold;
    turn_nxt    = turn;
    preempt_nxt = 1'b0;
    arb         = 1'b0;
    case (state)
      IDLE: arb = 1'b1;
      TURN: begin
        if (turn == '0) arb = 1'b1;
        else            turn_nxt = turn - 1'b1;
      end
      GRANT: begin
        if (own_done || !own_req || force_rel) begin
          // a coinciding done or dropped request is an ordinary release
          preempt_nxt = force_rel && own_req && !own_done;
          hold_nxt    = '0;
          if (TURNAROUND > 0) begin
            state_nxt = TURN;
            turn_nxt  = TW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
          end else begin
            arb = 1'b1;
          end
        end else if (!at_max) begin
          hold_nxt = hold + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (arb) begin
      if (win_vld) begin
        state_nxt = GRANT;
        last_nxt  = win;
        hold_nxt  = HW'(1);
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      last      <= IW'(N_REQ - 1);
      hold      <= '0;
      turn      <= '0;
      o_preempt <= 1'b0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      hold      <= hold_nxt;
      turn      <= turn_nxt;
      o_preempt <= preempt_nxt;
    end
  end

  // outputs decode straight from flops, so reset clears them without waiting for an edge
  assign o_busy     = (state == GRANT);
  assign o_gnt      = o_busy ? own_mask : '0;
  assign o_drive_en = o_gnt;
  assign o_owner    = o_busy ? last : '0;

`ifdef TRIBUS_ARBITER_PROTOCOL_CHECK_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)
      o_err <= 1'b0;
    else if ((|(i_done & ~o_gnt)) || (o_busy && !own_req && !own_done))
      o_err <= 1'b1;
  end

  a_gnt_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst) $onehot0(o_gnt));
  a_turn_idle:   assert property (@(posedge i_clk) disable iff (!i_rst) (state == TURN) |-> (o_gnt == '0));
`endif
endmodule

// File: tb/tb_tribus_arbiter.sv
// Scoreboard bench: three arbiter configurations against a cycle-level reference model.
module tb_tribus_arbiter;
  localparam int ND = 3;

  function automatic int nr(input int d); return (d == 2) ? 5 : 4; endfunction
  function automatic int ta(input int d); return (d == 0) ? 1 : ((d == 1) ? 0 : 2); endfunction
  function automatic int mh(input int d); return (d == 0) ? 16 : ((d == 1) ? 4 : 3); endfunction

  logic       clk;
  logic       rst;
  logic [4:0] req [ND];
  logic [4:0] done[ND];
  logic [3:0] g0, e0, g1, e1;
  logic [4:0] g2, e2;
  logic       b0, b1, b2, p0, p1, p2;
  logic [1:0] o0, o1;
  logic [2:0] o2;
`ifdef TRIBUS_ARBITER_PROTOCOL_CHECK_EN
  logic       x0, x1, x2;
`endif

  tribus_arbiter #(.N_REQ(4), .TURNAROUND(1), .MAX_HOLD(16)) u0 (
    .i_clk(clk), .i_rst(rst), .i_req(req[0][3:0]), .i_done(done[0][3:0]),
    .o_gnt(g0), .o_drive_en(e0), .o_busy(b0), .o_owner(o0), .o_preempt(p0)
`ifdef TRIBUS_ARBITER_PROTOCOL_CHECK_EN
    , .o_err(x0)
`endif
  );
  tribus_arbiter #(.N_REQ(4), .TURNAROUND(0), .MAX_HOLD(4)) u1 (
    .i_clk(clk), .i_rst(rst), .i_req(req[1][3:0]), .i_done(done[1][3:0]),
    .o_gnt(g1), .o_drive_en(e1), .o_busy(b1), .o_owner(o1), .o_preempt(p1)
`ifdef TRIBUS_ARBITER_PROTOCOL_CHECK_EN
    , .o_err(x1)
`endif
  );
  tribus_arbiter #(.N_REQ(5), .TURNAROUND(2), .MAX_HOLD(3)) u2 (
    .i_clk(clk), .i_rst(rst), .i_req(req[2]), .i_done(done[2]),
    .o_gnt(g2), .o_drive_en(e2), .o_busy(b2), .o_owner(o2), .o_preempt(p2)
`ifdef TRIBUS_ARBITER_PROTOCOL_CHECK_EN
    , .o_err(x2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] gnt_of(input int d);
    return (d == 0) ? {1'b0, g0} : ((d == 1) ? {1'b0, g1} : g2);
  endfunction
  function automatic logic [4:0] en_of(input int d);
    return (d == 0) ? {1'b0, e0} : ((d == 1) ? {1'b0, e1} : e2);
  endfunction
  function automatic logic [2:0] own_of(input int d);
    return (d == 0) ? {1'b0, o0} : ((d == 1) ? {1'b0, o1} : o2);
  endfunction
  function automatic logic busy_of(input int d); return (d == 0) ? b0 : ((d == 1) ? b1 : b2); endfunction
  function automatic logic pre_of(input int d);  return (d == 0) ? p0 : ((d == 1) ? p1 : p2); endfunction

  typedef struct {
    int         d;
    logic [4:0] gnt;
    logic       busy;
    logic [2:0] owner;
    logic       pre;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pre_seen[ND];

  // reference model: owner = -1 means bus free; gap = idle cycles still owed
  int m_owner[ND], m_last[ND], m_held[ND], m_gap[ND];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic pick(input int d, input logic [4:0] r);
    for (int k = 1; k <= nr(d); k++) begin
      int i;
      i = (m_last[d] + k) % nr(d);
      if (r[i] && m_owner[d] < 0) begin
        m_owner[d] = i;
        m_last[d]  = i;
        m_held[d]  = 1;
      end
    end
  endtask

  task automatic model_step(input int d, input logic rn, input logic [4:0] r_in, input logic [4:0] dn);
    logic [4:0] r;
    bit         pre;
    exp_t       e;
    r   = r_in & ((5'd1 << nr(d)) - 5'd1);
    pre = 0;
    if (!rn) begin
      m_owner[d] = -1; m_last[d] = nr(d) - 1; m_held[d] = 0; m_gap[d] = 0;
    end else if (m_owner[d] >= 0) begin
      int o;
      bit others, hit;
      o      = m_owner[d];
      others = (r & ~(5'd1 << o)) != 0;
      hit    = (mh(d) > 0) && (m_held[d] == mh(d)) && others;
      if (dn[o] || !r[o] || hit) begin
        pre        = hit && !dn[o] && r[o];
        m_owner[d] = -1;
        m_gap[d]   = ta(d);
        if (ta(d) == 0) pick(d, r);
      end else if (mh(d) == 0 || m_held[d] < mh(d)) begin
        m_held[d]++;
      end
    end else begin
      if (m_gap[d] > 0) m_gap[d]--;
      if (m_gap[d] == 0) pick(d, r);
    end
    e.d     = d;
    e.gnt   = (m_owner[d] >= 0) ? (5'd1 << m_owner[d]) : 5'd0;
    e.busy  = (m_owner[d] >= 0);
    e.owner = (m_owner[d] >= 0) ? 3'(m_owner[d]) : 3'd0;
    e.pre   = pre;
    q.push_back(e);
  endtask

  // stimulus for the coming edge -> expectations; returns at negedge+1 after the monitor ran
  task automatic tick(input logic rn);
    rst = rn;
    for (int d = 0; d < ND; d++) model_step(d, rn, req[d], done[d]);
    @(negedge clk);
    #1;
  endtask

  task automatic set_all(input logic [4:0] r, input logic [4:0] dn);
    for (int d = 0; d < ND; d++) begin
      req[d]  = r & ((5'd1 << nr(d)) - 5'd1);
      done[d] = dn & ((5'd1 << nr(d)) - 5'd1);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("onehot0_d%0d", d), {31'd0, $onehot0(gnt_of(d))}, 32'd1);
      chk($sformatf("drive_en_d%0d", d), {27'd0, en_of(d)}, {27'd0, gnt_of(d)});
      if (pre_of(d) === 1'b1) pre_seen[d]++;
    end
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk($sformatf("gnt_d%0d", e.d),     {27'd0, gnt_of(e.d)},  {27'd0, e.gnt});
      chk($sformatf("busy_d%0d", e.d),    {31'd0, busy_of(e.d)}, {31'd0, e.busy});
      chk($sformatf("owner_d%0d", e.d),   {29'd0, own_of(e.d)},  {29'd0, e.owner});
      chk($sformatf("preempt_d%0d", e.d), {31'd0, pre_of(e.d)},  {31'd0, e.pre});
    end
  end

  initial begin
    for (int d = 0; d < ND; d++) pre_seen[d] = 0;
    set_all(5'd0, 5'd0);
    rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    tick(0); tick(0);
    chk("rst_gnt0", {28'd0, g0}, 0); chk("rst_gnt1", {28'd0, g1}, 0); chk("rst_gnt2", {27'd0, g2}, 0);
    chk("rst_busy0", {31'd0, b0}, 0); chk("rst_owner0", {30'd0, o0}, 0); chk("rst_pre0", {31'd0, p0}, 0);

    // single requester: grant next cycle, release on done
    set_all(5'b00001, 5'd0); tick(1);
    chk("first_gnt0", {28'd0, g0}, 32'h1); chk("first_owner0", {30'd0, o0}, 0);
    chk("first_busy0", {31'd0, b0}, 1); chk("first_gnt2", {27'd0, g2}, 32'h1);
    tick(1); tick(1);
    set_all(5'b00001, 5'b00001); tick(1);
    chk("done_rel_gnt0", {28'd0, g0}, 0);
    set_all(5'b00001, 5'd0); tick(1);
    chk("regrant_gnt0", {28'd0, g0}, 32'h1);

    // asynchronous reset between edges while granted
    rst = 1'b0;
    #1;
    chk("async_gnt0", {28'd0, g0}, 0); chk("async_en0", {28'd0, e0}, 0);
    chk("async_gnt1", {28'd0, g1}, 0); chk("async_busy1", {31'd0, b1}, 0);
    set_all(5'd0, 5'd0); tick(0);

    // two requesters, owner 0 releases: turnaround 1 / 0 / 2
    set_all(5'b00011, 5'd0); tick(1);
    chk("restart_gnt2", {27'd0, g2}, 32'h1); chk("restart_gnt0", {28'd0, g0}, 32'h1);
    tick(1); tick(1);
    set_all(5'b00011, 5'b00001); tick(1);
    chk("ta_rel_gnt0", {28'd0, g0}, 0); chk("ta0_handover_gnt1", {28'd0, g1}, 32'h2);
    chk("ta2_gap1_gnt2", {27'd0, g2}, 0); chk("done_beats_preempt_p2", {31'd0, p2}, 0);
    set_all(5'b00011, 5'd0); tick(1);
    chk("ta1_next_gnt0", {28'd0, g0}, 32'h2); chk("ta2_gap2_gnt2", {27'd0, g2}, 0);
    tick(1);
    chk("ta2_next_gnt2", {27'd0, g2}, 32'h2);

    // everyone requesting, owner pulses done every third cycle
    for (int c = 0; c < 15; c++) begin
      for (int d = 0; d < ND; d++) begin
        req[d]  = (5'd1 << nr(d)) - 5'd1;
        done[d] = (c % 3 == 2 && m_owner[d] >= 0) ? (5'd1 << m_owner[d]) : 5'd0;
      end
      tick(1);
    end

    // hold limit: requester 2 never releases, requester 3 waits
    set_all(5'd0, 5'd0);
    for (int c = 0; c < 4; c++) tick(1);
    set_all(5'b00100, 5'd0); tick(1);
    set_all(5'b01100, 5'd0);
    tick(1); tick(1); tick(1);
    chk("hold_gnt1", {28'd0, g1}, 32'h4); chk("preempt_p2", {31'd0, p2}, 1);
    tick(1);
    chk("preempt_next_gnt1", {28'd0, g1}, 32'h8); chk("preempt_p1", {31'd0, p1}, 1);
    chk("preempt_once_p2", {31'd0, p2}, 0);
    for (int c = 0; c < 8; c++) tick(1);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int d = 0; d < ND; d++) begin
        logic [4:0] r, dn;
        r  = req[d];
        dn = 5'd0;
        for (int i = 0; i < nr(d); i++) begin
          if (done[d][i] && ($urandom % 2 == 0)) r[i] = 1'b0;
          else if (!r[i] && ($urandom % 4 == 0)) r[i] = 1'b1;
          else if (r[i] && ($urandom % 25 == 0)) r[i] = 1'b0;
          if ($urandom % 10 == 0) dn[i] = 1'b1;
        end
        req[d]  = r;
        done[d] = dn;
      end
      tick(1);
    end

    chk("queue_drained", q.size(), 0);
    chk("preempt_seen_d1", {31'd0, pre_seen[1] > 0}, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
